// File: rtl/console_tx_arbiter.sv
// Round-robin arbiter that merges N_REQ 4-phase valid/ack byte producers into
// the single console output stream through a small ready/valid FIFO.
module console_tx_arbiter #(
   parameter int N_REQ      = 2,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [N_REQ-1:0]            REQ_valid,
   input  logic [N_REQ*DATA_W-1:0]     REQ_data,
   output logic [N_REQ-1:0]            REQ_ack,
   output logic [DATA_W-1:0]           CONSOLE_OUT,
   output logic                        CONSOLE_OUT_valid,
   input  logic                        CONSOLE_OUT_ready,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RR_W  = $clog2(N_REQ);
   localparam int RR_W1 = RR_W + 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} req_state_t;

   req_state_t          state_r [N_REQ];
   logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic [RR_W-1:0]     rr_ptr_r;
   logic [N_REQ-1:0]    eligible_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic                push_s;
   logic                pop_s;
   logic                grant_vld_s;
   logic [RR_W-1:0]     grant_idx_s;
   logic [RR_W:0]       cand_w_s;
   logic [RR_W-1:0]     cand_s;

   assign fifo_full_s       = (count_r == CNT_W'(FIFO_DEPTH));
   assign fifo_empty_s      = (count_r == {CNT_W{1'b0}});
   assign push_s            = grant_vld_s;
   assign pop_s             = !fifo_empty_s && CONSOLE_OUT_ready;
   assign CONSOLE_OUT_valid = !fifo_empty_s;
   assign CONSOLE_OUT       = fifo_empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
   assign FIFO_count        = count_r;

   // Per-requester acknowledge and eligibility decode
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         REQ_ack[i]    = (state_r[i] == ST_ACK);
         eligible_s[i] = REQ_valid[i] && (state_r[i] == ST_IDLE);
      end
   end

   // Round-robin search starting at rr_ptr_r; a full FIFO blocks every grant,
   // even when a pop happens on the same edge
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = {RR_W{1'b0}};
      cand_w_s    = {RR_W1{1'b0}};
      cand_s      = {RR_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         cand_w_s = {1'b0, rr_ptr_r} + RR_W1'(k);
         if (cand_w_s >= RR_W1'(N_REQ)) begin
            cand_w_s = cand_w_s - RR_W1'(N_REQ);
         end else begin
            cand_w_s = cand_w_s;
         end
         cand_s = cand_w_s[RR_W-1:0];
         if (!fifo_full_s && !grant_vld_s && eligible_s[cand_s]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = cand_s;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // Requester handshake FSMs and round-robin pointer
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < N_REQ; i++) begin
            state_r[i] <= ST_IDLE;
         end
         rr_ptr_r <= {RR_W{1'b0}};
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            case (state_r[i])
               ST_IDLE: state_r[i] <= (grant_vld_s && (grant_idx_s == RR_W'(i))) ? ST_ACK : ST_IDLE;
               ST_ACK:  state_r[i] <= REQ_valid[i] ? ST_ACK : ST_IDLE;
               default: state_r[i] <= ST_IDLE;
            endcase
         end
         if (grant_vld_s) begin
            rr_ptr_r <= (grant_idx_s == RR_W'(N_REQ - 1)) ? {RR_W{1'b0}} : grant_idx_s + RR_W'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Output FIFO storage, pointers and occupancy
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int e = 0; e < FIFO_DEPTH; e++) begin
            mem_r[e] <= {DATA_W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= REQ_data[int'(grant_idx_s)*DATA_W +: DATA_W];
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_console_tx_arbiter.sv
// Directed self-checking bench for console_tx_arbiter (N_REQ=2, DATA_W=8,
// FIFO_DEPTH=4) with hand-computed expectations.
module tb_console_tx_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       v0, v1;
   logic [7:0] d0, d1;
   logic [1:0] req_valid;
   logic [15:0] req_data;
   logic [1:0] ack;
   logic [7:0] out;
   logic       out_valid;
   logic       ready;
   logic [2:0] count;

   int checks   = 0;
   int failures = 0;
   int sent0, sent1, got;
   logic [7:0] rr_exp [8];
   logic [7:0] drain_exp [3];

   assign req_valid = {v1, v0};
   assign req_data  = {d1, d0};

   console_tx_arbiter #(.N_REQ(2), .DATA_W(8), .FIFO_DEPTH(4)) dut (
      .CLK               (clk),
      .RESET             (rst_n),
      .REQ_valid         (req_valid),
      .REQ_data          (req_data),
      .REQ_ack           (ack),
      .CONSOLE_OUT       (out),
      .CONSOLE_OUT_valid (out_valid),
      .CONSOLE_OUT_ready (ready),
      .FIFO_count        (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rr_exp    = '{8'h30, 8'h60, 8'h31, 8'h61, 8'h32, 8'h62, 8'h33, 8'h63};
      drain_exp = '{8'h03, 8'h04, 8'h05};
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; ready = 1'b0;
      #12;
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_out", 32'(out), 32'h0);
      tick();
      rst_n = 1'b1;

      // single request
      ready = 1'b1; d0 = 8'h50; v0 = 1'b1;
      tick();
      chk("single_ack", 32'(ack), 32'h1);
      chk("single_valid", 32'(out_valid), 32'h1);
      chk("single_out", 32'(out), 32'h50);
      chk("single_count", 32'(count), 32'h1);
      v0 = 1'b0;
      tick();
      chk("single_ack_clr", 32'(ack), 32'h0);
      chk("single_valid_1cyc", 32'(out_valid), 32'h0);
      chk("single_out_empty", 32'(out), 32'h0);

      // contention from reset
      rst_n = 1'b0; #2; rst_n = 1'b1;
      ready = 1'b0; d0 = 8'h41; d1 = 8'h42; v0 = 1'b1; v1 = 1'b1;
      tick();
      chk("cont_ack_first", 32'(ack), 32'h1);
      chk("cont_head", 32'(out), 32'h41);
      v0 = 1'b0;
      tick();
      chk("cont_ack_second", 32'(ack), 32'h2);
      chk("cont_count", 32'(count), 32'h2);
      v1 = 1'b0;
      ready = 1'b1;
      chk("cont_out0", 32'(out), 32'h41);
      tick();
      chk("cont_out1", 32'(out), 32'h42);
      tick();
      chk("cont_empty", 32'(count), 32'h0);

      // round-robin fairness with continuous re-issue
      sent0 = 0; sent1 = 0; got = 0;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            if (got < 8) chk("rr_order", 32'(out), 32'(rr_exp[got]));
            got++;
         end
         if (ack[0] && v0) v0 = 1'b0;
         else if (!ack[0] && !v0 && sent0 < 4) begin d0 = 8'h30 + 8'(sent0); v0 = 1'b1; sent0++; end
         if (ack[1] && v1) v1 = 1'b0;
         else if (!ack[1] && !v1 && sent1 < 4) begin d1 = 8'h60 + 8'(sent1); v1 = 1'b1; sent1++; end
         tick();
      end
      chk("rr_total", 32'(got), 32'd8);

      // fill to full with back-pressure
      ready = 1'b0; sent0 = 0;
      for (int c = 0; c < 12; c++) begin
         if (ack[0] && v0) v0 = 1'b0;
         else if (!ack[0] && !v0 && sent0 < 5) begin d0 = 8'h01 + 8'(sent0); v0 = 1'b1; sent0++; end
         tick();
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_no_ack", 32'(ack), 32'h0);
      chk("full_head", 32'(out), 32'h01);
      ready = 1'b1;
      tick();
      chk("full_pop_no_push_ack", 32'(ack), 32'h0);
      chk("full_pop_count", 32'(count), 32'd3);
      chk("full_pop_head", 32'(out), 32'h02);
      tick();
      chk("full_fifth_ack", 32'(ack), 32'h1);
      chk("full_fifth_count", 32'(count), 32'd3);
      v0 = 1'b0;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) begin
            if (got < 3) chk("full_drain", 32'(out), 32'(drain_exp[got]));
            got++;
         end
         tick();
      end
      chk("full_drain_total", 32'(got), 32'd3);

      // simultaneous push and pop at count 2
      ready = 1'b0;
      d0 = 8'hA0; v0 = 1'b1; tick(); v0 = 1'b0; tick();
      d0 = 8'hA1; v0 = 1'b1; tick(); v0 = 1'b0; tick();
      chk("pp_pre_count", 32'(count), 32'd2);
      ready = 1'b1; d1 = 8'hB0; v1 = 1'b1;
      tick();
      chk("pp_count", 32'(count), 32'd2);
      chk("pp_head", 32'(out), 32'hA1);
      chk("pp_ack", 32'(ack), 32'h2);
      v1 = 1'b0; ready = 1'b0;
      tick();
      ready = 1'b1;
      tick();
      chk("pp_order", 32'(out), 32'hB0);
      tick();
      chk("pp_empty", 32'(out_valid), 32'h0);

      // asynchronous reset mid-operation
      ready = 1'b0;
      d0 = 8'hC0; v0 = 1'b1; tick(); v0 = 1'b0; tick();
      d0 = 8'hC1; v0 = 1'b1; tick(); v0 = 1'b0; tick();
      d1 = 8'hD0; v1 = 1'b1; tick();
      chk("mid_pre_count", 32'(count), 32'd3);
      chk("mid_pre_ack", 32'(ack), 32'h2);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_ack", 32'(ack), 32'h0);
      chk("mid_rst_count", 32'(count), 32'h0);
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("mid_reack", 32'(ack), 32'h2);
      chk("mid_out", 32'(out), 32'hD0);
      chk("mid_count", 32'(count), 32'd1);
      v1 = 1'b0; ready = 1'b1;
      tick();
      chk("mid_once_count", 32'(count), 32'd0);
      chk("mid_ack_clr", 32'(ack), 32'h0);
      tick();
      chk("mid_once_valid", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/console_tx_arbiter.md
Name: console_tx_arbiter

Overview:
- Shares the single 8-bit CONSOLE_OUT channel of the Wrapper between N_REQ byte producers, e.g. processor MMIO stores to the console address and a debug dumper of SEVENSEGHEX/DIP values.
- Each requester uses the same 4-phase valid/ack handshake as the CONSOLE_IN path.
- Requests are granted round-robin into a small FIFO.
- The FIFO drains to the UART side over a ready/valid handshake.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- REQ_valid  input  N_REQ  per-requester request; data must be stable while high.
- REQ_data  input  N_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W].
- REQ_ack  output  N_REQ  per-requester acknowledge; registered.
- CONSOLE_OUT  output  DATA_W  FIFO head byte.
- CONSOLE_OUT_valid  output  1  FIFO non-empty.
- CONSOLE_OUT_ready  input  1  UART side can accept a byte.
- FIFO_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (RESET=0, asynchronous): REQ_ack=0, FIFO empty, FIFO_count=0, CONSOLE_OUT_valid=0, CONSOLE_OUT=0, round-robin pointer=0.
  - Reset mid-handshake drops all acks and discards buffered bytes.
  - A requester still holding valid after reset is treated as a new request.
- Per-requester FSM, 2 states:
  - IDLE: REQ_ack[i]=0; eligible when REQ_valid[i]=1.
  - ACK: REQ_ack[i]=1; not eligible. Return to IDLE on the edge where REQ_valid[i] is sampled 0.
- Arbitration, once per cycle:
  - If FIFO_count < FIFO_DEPTH, pick the first eligible requester, searching i = ptr, ptr+1, ... (mod N_REQ).
  - On that edge: push REQ_data[i], move requester i to ACK, set ptr=(i+1) mod N_REQ.
  - Maximum one grant per cycle. Other requesters can sit in ACK at the same time.
- Full FIFO: no grant. This holds even if a pop happens the same cycle, so a pop cannot free a slot for a same-cycle push. Requesters wait with valid held; no byte is ever dropped.
- Latency:
  - REQ_valid high and sampled at edge k with no contention and FIFO not full: REQ_ack=1 after edge k.
  - If the FIFO was empty, CONSOLE_OUT_valid=1 with CONSOLE_OUT=byte after the same edge k.
- Output side:
  - CONSOLE_OUT is combinationally the head entry (0 when empty). CONSOLE_OUT_valid = (count != 0).
  - Pop on an edge with CONSOLE_OUT_valid & CONSOLE_OUT_ready.
  - Ready while empty has no effect.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, order preserved.
- Count and pointers:
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - FIFO_count ranges 0..FIFO_DEPTH and never over- or underflows.
- Ordering: FIFO order equals grant order. Bytes from a single requester leave in issue order.

Test Plan:
- Single request, N_REQ=2, FIFO_DEPTH=4:
  - Stimulus: req0 valid with 0x50, ready=1.
  - Required: REQ_ack[0] high 1 edge later; CONSOLE_OUT=0x50 with valid for exactly 1 cycle. After valid drops, ack clears on the next edge.
- Contention:
  - Stimulus: req0=0x41 and req1=0x42 asserted the same cycle from reset.
  - Required: 0x41 granted first (ptr=0), 0x42 next cycle; output order 0x41, 0x42.
- Round-robin fairness:
  - Stimulus: both requesters re-issue continuously with ready=1; req0 sends 0x30..0x33, req1 sends 0x60..0x63.
  - Required: output strictly alternates 0x30, 0x60, 0x31, 0x61, ...
- Full and back-pressure:
  - Stimulus: ready=0; req0 sends 0x01..0x05 via 4-phase handshake.
  - Required: FIFO_count reaches 4 and the 5th request stays unacked.
  - Then ready=1: outputs 0x01..0x04, then 0x05 is acked and output. No byte is lost.
- Simultaneous push/pop at count=2:
  - Required: FIFO_count stays 2 and the head advances correctly.
- Reset mid-operation:
  - Stimulus: RESET=0 asynchronously with count=3 and REQ_ack[1]=1.
  - Required: ack, count and valid go to 0 immediately, without waiting for CLK.
  - After release with req1 still valid: req1 is re-acked and its byte is output once.
